// File: rtl/axi_master_if.sv
// axi_master_if: one-at-a-time AXI3 initiator turning client commands into AW/W/B or AR/R bursts.
// Optional watchdog abort on stalled handshakes is built when AXI_MASTER_TIMEOUT_EN is defined.
module axi_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TMO_MAX = 255
) (
    input  logic                a_clk,
    input  logic                a_resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [1:0]          cmd_burst,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [ID_W-1:0]     rd_id,
    output logic [1:0]          rd_resp,
    output logic                rd_last,
    output logic                done_valid,
    output logic [1:0]          done_resp,
    output logic                done_err,
    output logic                aw_valid,
    input  logic                aw_ready,
    output logic [ID_W-1:0]     aw_id,
    output logic [ADDR_W-1:0]   aw_addr,
    output logic [3:0]          aw_len,
    output logic [2:0]          aw_size,
    output logic [1:0]          aw_burst,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [ID_W-1:0]     w_id,
    output logic [DATA_W-1:0]   w_data,
    output logic [DATA_W/8-1:0] w_strb,
    output logic                w_last,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ID_W-1:0]     b_id,
    input  logic [1:0]          b_resp,
    output logic                ar_valid,
    input  logic                ar_ready,
    output logic [ID_W-1:0]     ar_id,
    output logic [ADDR_W-1:0]   ar_addr,
    output logic [3:0]          ar_len,
    output logic [2:0]          ar_size,
    output logic [1:0]          ar_burst,
    input  logic                r_valid,
    output logic                r_ready,
    input  logic [ID_W-1:0]     r_id,
    input  logic [DATA_W-1:0]   r_data,
    input  logic [1:0]          r_resp,
    input  logic                r_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW_REQ,
        S_W_DATA,
        S_B_WAIT,
        S_AR_REQ,
        S_R_DATA,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          resp_q, resp_d;
    logic                err_q, err_d;
    logic                tmo_hit;
    logic                in_w, in_r, at_len;

    assign in_w   = (state_q == S_W_DATA);
    assign in_r   = (state_q == S_R_DATA);
    assign at_len = (cnt_q == len_q);

    assign cmd_ready = (state_q == S_IDLE);

    assign aw_valid = (state_q == S_AW_REQ);
    assign aw_id    = id_q;
    assign aw_addr  = addr_q;
    assign aw_len   = len_q;
    assign aw_size  = aw_valid ? 3'b010 : 3'b000;
    assign aw_burst = burst_q;

    assign w_valid  = in_w && wd_valid;
    assign wd_ready = in_w && w_ready;
    assign w_id     = id_q;
    assign w_data   = in_w ? wd_data : '0;
    assign w_strb   = in_w ? wd_strb : '0;
    assign w_last   = in_w && at_len;

    assign b_ready  = (state_q == S_B_WAIT);

    assign ar_valid = (state_q == S_AR_REQ);
    assign ar_id    = id_q;
    assign ar_addr  = addr_q;
    assign ar_len   = len_q;
    assign ar_size  = ar_valid ? 3'b010 : 3'b000;
    assign ar_burst = burst_q;

    // Read beats bypass any register so the client sees them in the R cycle.
    assign r_ready  = in_r;
    assign rd_valid = in_r && r_valid;
    assign rd_data  = rd_valid ? r_data : '0;
    assign rd_id    = rd_valid ? r_id : '0;
    assign rd_resp  = rd_valid ? r_resp : 2'b00;
    assign rd_last  = rd_valid && r_last;

    assign done_valid = (state_q == S_DONE);
    assign done_resp  = done_valid ? resp_q : 2'b00;
    assign done_err   = done_valid && err_q;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TMO_MAX);

    logic [7:0] tmo_q, tmo_d;
    logic       busy, hs_act;

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign hs_act = (aw_valid && aw_ready) || (w_valid && w_ready) ||
                    (b_ready && b_valid) || (ar_valid && ar_ready) ||
                    (r_ready && r_valid);
    assign tmo_hit = busy && !hs_act && (tmo_q == TMO_LIM);

    always_comb begin
        tmo_d = 8'd0;
        if (busy && !hs_act && !tmo_hit) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = (TMO_MAX == 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    id_d    = cmd_id;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    burst_d = cmd_burst;
                    cnt_d   = 4'd0;
                    resp_d  = 2'b00;
                    err_d   = 1'b0;
                    state_d = cmd_write ? S_AW_REQ : S_AR_REQ;
                end
            end
            S_AW_REQ: begin
                if (aw_ready) state_d = S_W_DATA;
            end
            S_W_DATA: begin
                if (w_valid && w_ready) begin
                    if (at_len) begin
                        cnt_d   = 4'd0;
                        state_d = S_B_WAIT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_B_WAIT: begin
                if (b_valid) begin
                    resp_d  = b_resp;
                    err_d   = (b_id != id_q);
                    state_d = S_DONE;
                end
            end
            S_AR_REQ: begin
                if (ar_ready) state_d = S_R_DATA;
            end
            S_R_DATA: begin
                if (r_valid) begin
                    if (r_resp > resp_q) resp_d = r_resp;
                    if ((r_id != id_q) || (r_last != at_len)) err_d = 1'b1;
                    // Counter saturates at len; only r_last ends the burst.
                    if (r_last) begin
                        cnt_d   = 4'd0;
                        state_d = S_DONE;
                    end else if (!at_len) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (tmo_hit) begin
            cnt_d   = 4'd0;
            resp_d  = 2'b10;
            err_d   = 1'b1;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= 4'd0;
            burst_q <= 2'b00;
            cnt_q   <= 4'd0;
            resp_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_master_if.sv
// tb_axi_master_if: directed write/read bursts against axi_master_if.
// Expected AW/AR/W/RD/DONE traffic is queued by stimulus and checked by a monitor.
module tb_axi_master_if;

    logic        a_clk = 1'b0;
    logic        a_resetn = 1'b0;
    logic        cmd_valid = 0, cmd_write = 0;
    logic [3:0]  cmd_id = 0, cmd_len = 0;
    logic [31:0] cmd_addr = 0;
    logic [1:0]  cmd_burst = 0;
    logic        cmd_ready;
    logic        wd_valid = 0, wd_ready;
    logic [31:0] wd_data = 0;
    logic [3:0]  wd_strb = 0;
    logic        rd_valid, rd_last;
    logic [31:0] rd_data;
    logic [3:0]  rd_id;
    logic [1:0]  rd_resp;
    logic        done_valid, done_err;
    logic [1:0]  done_resp;
    logic        aw_valid, aw_ready = 0;
    logic [3:0]  aw_id, aw_len;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready = 0, w_last;
    logic [3:0]  w_id, w_strb;
    logic [31:0] w_data;
    logic        b_valid = 0, b_ready;
    logic [3:0]  b_id = 0;
    logic [1:0]  b_resp = 0;
    logic        ar_valid, ar_ready = 0;
    logic [3:0]  ar_id, ar_len;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid = 0, r_ready, r_last = 0;
    logic [3:0]  r_id = 0;
    logic [31:0] r_data = 0;
    logic [1:0]  r_resp = 0;

    int ntotal = 0;
    int npass  = 0;

    logic [63:0] q_aw[$], q_ar[$], q_w[$], q_rd[$], q_done[$];
    logic [31:0] wbuf[16];
    logic [3:0]  sbuf[16];
    logic [1:0]  rresp[16];

    always #5 a_clk = ~a_clk;

    axi_master_if dut (
        .a_clk(a_clk), .a_resetn(a_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_resp(rd_resp),
        .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_id(w_id), .w_data(w_data),
        .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    task automatic miss(input string nm, input string what);
        ntotal++;
        $display("FAIL %s: got %s", nm, what);
    endtask

    always @(negedge a_clk) begin
        if (a_resetn) begin
            if (aw_valid && aw_ready) begin
                if (q_aw.size() == 0) miss("aw", "unexpected handshake");
                else chk("aw", {aw_id, aw_addr, aw_len, aw_size, aw_burst}, q_aw.pop_front());
            end
            if (ar_valid && ar_ready) begin
                if (q_ar.size() == 0) miss("ar", "unexpected handshake");
                else chk("ar", {ar_id, ar_addr, ar_len, ar_size, ar_burst}, q_ar.pop_front());
            end
            if (w_valid && w_ready) begin
                if (q_w.size() == 0) miss("w", "unexpected beat");
                else chk("w", {w_id, w_data, w_strb, w_last, wd_ready}, q_w.pop_front());
            end
            if (rd_valid) begin
                if (q_rd.size() == 0) miss("rd", "unexpected beat");
                else chk("rd", {rd_data, rd_id, rd_resp, rd_last}, q_rd.pop_front());
            end
            if (done_valid) begin
                if (q_done.size() == 0) miss("done", "unexpected pulse");
                else chk("done", {done_resp, done_err}, q_done.pop_front());
            end
        end
    end

    task automatic do_cmd(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
        int k;
        bit hs;
        cmd_valid = 1; cmd_write = wr; cmd_id = id;
        cmd_addr = addr; cmd_len = len; cmd_burst = burst;
        if (wr) q_aw.push_back({id, addr, len, 3'b010, burst});
        else q_ar.push_back({id, addr, len, 3'b010, burst});
        k = 0; hs = 0;
        while (!hs && k < 100) begin
            @(negedge a_clk); hs = cmd_ready;
            @(posedge a_clk); #1; k++;
        end
        cmd_valid = 0;
        if (!hs) miss("cmd_accept", "no handshake");
        else chk("ax_latency", wr ? aw_valid : ar_valid, 1);
    endtask

    task automatic slave_write(input logic [3:0] wid, input int len, input bit toggle,
                               input logic [3:0] bid, input logic [1:0] bresp);
        int k, beat;
        bit hs;
        for (int i = 0; i <= len; i++)
            q_w.push_back({wid, wbuf[i], sbuf[i], (i == len), 1'b1});
        k = 0;
        while (!aw_valid && k < 100) begin @(posedge a_clk); #1; k++; end
        if (!aw_valid) miss("aw_wait", "no aw_valid");
        aw_ready = 1;
        @(posedge a_clk); #1;
        aw_ready = 0;
        k = 0; beat = 0;
        while (beat <= len && k < 200) begin
            wd_valid = 1; wd_data = wbuf[beat]; wd_strb = sbuf[beat];
            w_ready = toggle ? k[0] : 1'b1;
            @(negedge a_clk); hs = w_ready && wd_valid;
            @(posedge a_clk); #1;
            if (hs) beat++;
            k++;
        end
        wd_valid = 0; w_ready = 0;
        if (beat <= len) miss("w_wait", "too few beats accepted");
        b_valid = 1; b_id = bid; b_resp = bresp;
        k = 0; hs = 0;
        while (!hs && k < 100) begin
            @(negedge a_clk); hs = b_ready;
            @(posedge a_clk); #1; k++;
        end
        b_valid = 0;
        if (!hs) miss("b_wait", "no b_ready");
    endtask

    task automatic slave_read(input logic [3:0] rid, input int n, input int last_at);
        int k;
        k = 0;
        while (!ar_valid && k < 100) begin @(posedge a_clk); #1; k++; end
        if (!ar_valid) miss("ar_wait", "no ar_valid");
        ar_ready = 1;
        @(posedge a_clk); #1;
        ar_ready = 0;
        for (int i = 0; i < n; i++) begin
            r_valid = 1; r_id = rid; r_data = 32'hC000_0000 + 32'(i);
            r_resp = rresp[i]; r_last = (i == last_at);
            q_rd.push_back({r_data, rid, rresp[i], r_last});
            @(posedge a_clk); #1;
        end
        r_valid = 0; r_last = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge a_clk);
        #1;
    endtask

    task automatic clr_rresp();
        for (int i = 0; i < 16; i++) rresp[i] = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang, required $finish");
        $fatal(1);
    end

    initial begin
        int k, bad;
        bit seen;
        clr_rresp();
        #15;
        chk("rst_ctl", {cmd_ready, wd_ready, rd_valid, done_valid, aw_valid,
                        w_valid, b_ready, ar_valid, r_ready}, 9'b100000000);
        chk("rst_aw", {aw_id, aw_addr, aw_len, aw_size, aw_burst}, 0);
        chk("rst_ar", {ar_id, ar_addr, ar_len, ar_size, ar_burst}, 0);
        chk("rst_w", {w_id, w_data, w_strb, w_last}, 0);
        chk("rst_rd", {rd_data, rd_id, rd_resp, rd_last, done_resp, done_err}, 0);
        @(posedge a_clk); #1;
        a_resetn = 1;
        idle(2);

        // single-beat write
        wbuf[0] = 32'hA5A5_A5A5; sbuf[0] = 4'hF;
        do_cmd(1, 4'd0, 32'h0, 4'd0, 2'b01);
        q_done.push_back({2'b00, 1'b0});
        slave_write(4'd0, 0, 0, 4'd0, 2'b00);
        idle(3);

        // 4-beat write with toggling w_ready
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'h1111_0000 + 32'(i);
            sbuf[i] = 4'(i + 5);
        end
        do_cmd(1, 4'd3, 32'h100, 4'd3, 2'b01);
        q_done.push_back({2'b00, 1'b0});
        slave_write(4'd3, 3, 1, 4'd3, 2'b00);
        idle(3);

        // 16-beat read
        clr_rresp();
        do_cmd(0, 4'd1, 32'h2000, 4'd15, 2'b01);
        q_done.push_back({2'b00, 1'b0});
        slave_read(4'd1, 16, 15);
        idle(3);

        // worst response across read beats
        clr_rresp();
        rresp[1] = 2'b11;
        do_cmd(0, 4'd7, 32'h44, 4'd2, 2'b10);
        q_done.push_back({2'b11, 1'b0});
        slave_read(4'd7, 3, 2);
        idle(3);

        // write B id mismatch, SLVERR passes through
        wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'h3;
        do_cmd(1, 4'd2, 32'h80, 4'd0, 2'b00);
        q_done.push_back({2'b10, 1'b1});
        slave_write(4'd2, 0, 0, 4'd5, 2'b10);
        idle(3);

        // next command held by the client during an active write
        wbuf[0] = 32'h0BAD_F00D; sbuf[0] = 4'hC;
        wbuf[1] = 32'h1234_5678; sbuf[1] = 4'h1;
        do_cmd(1, 4'd4, 32'h300, 4'd1, 2'b01);
        q_done.push_back({2'b00, 1'b0});
        cmd_valid = 1; cmd_write = 0; cmd_id = 4'd6;
        cmd_addr = 32'h3000; cmd_len = 4'd0; cmd_burst = 2'b01;
        q_ar.push_back({4'd6, 32'h3000, 4'd0, 3'b010, 2'b01});
        bad = 0; seen = 0;
        fork
            slave_write(4'd4, 1, 0, 4'd4, 2'b00);
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge a_clk);
                    if (done_valid) begin seen = 1; break; end
                    if (cmd_ready) bad++;
                end
                chk("stall_ready_low", bad, 0);
                if (!seen) miss("stall_done", "no done pulse");
                @(negedge a_clk);
                chk("accept_after_done", cmd_ready, 1);
            end
        join
        @(posedge a_clk); #1;
        cmd_valid = 0;
        clr_rresp();
        rresp[0] = 2'b01;
        q_done.push_back({2'b01, 1'b0});
        slave_read(4'd6, 1, 0);
        idle(3);

        // early r_last flags a protocol error and ends the burst
        clr_rresp();
        do_cmd(0, 4'd9, 32'h500, 4'd3, 2'b01);
        q_done.push_back({2'b00, 1'b1});
        slave_read(4'd9, 2, 1);
        idle(3);

        // reset mid-burst
        clr_rresp();
        do_cmd(0, 4'd5, 32'h600, 4'd3, 2'b01);
        slave_read(4'd5, 2, 99);
        chk("r_busy", r_ready, 1);
        #2;
        a_resetn = 0;
        #1;
        chk("async_rst", {cmd_ready, r_ready, rd_valid, done_valid, ar_valid}, 5'b10000);
        @(posedge a_clk); #1;
        a_resetn = 1;
        idle(2);
        do_cmd(0, 4'hE, 32'h40, 4'd0, 2'b01);
        q_done.push_back({2'b00, 1'b0});
        slave_read(4'hE, 1, 0);
        idle(3);

`ifdef AXI_MASTER_TIMEOUT_EN
        do_cmd(1, 4'd8, 32'h700, 4'd0, 2'b01);
        void'(q_aw.pop_back());
        q_done.push_back({2'b10, 1'b1});
        seen = 0;
        for (k = 0; k < 600 && !seen; k++) begin
            @(negedge a_clk);
            seen = done_valid;
        end
        if (!seen) miss("tmo_done", "no done pulse");
        @(negedge a_clk);
        chk("tmo_idle", {cmd_ready, aw_valid}, 2'b10);
        @(posedge a_clk); #1;
        idle(2);
`endif

        chk("aw_left", q_aw.size(), 0);
        chk("ar_left", q_ar.size(), 0);
        chk("w_left", q_w.size(), 0);
        chk("rd_left", q_rd.size(), 0);
        chk("done_left", q_done.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
